// File: rtl/primitive_graph_edge_loader.sv
`default_nettype none
// ============================================================================
//  Module      : primitive_graph_edge_loader
//  Description : Collects a serial edge stream for one node, merges duplicate
//                neighbours with saturating weight accumulation, and presents
//                the adjacency list as a parallel record via valid/ready.
//                Optional build macro GRAPH_LOADER_SELF_LOOP_FILTER_EN drops
//                self-loop edges silently instead of storing them.
//  Revision    : 1.0 - initial release
// ============================================================================
module primitive_graph_edge_loader #(
    parameter int NODE_ID_WIDTH = 8,
    parameter int WEIGHT_WIDTH  = 16,
    parameter int MAX_SLOTS     = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [NODE_ID_WIDTH-1:0]           in_node_id,
    input  logic [NODE_ID_WIDTH-1:0]           in_neighbor_id,
    input  logic [WEIGHT_WIDTH-1:0]            in_weight,
    input  logic                               in_null,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [NODE_ID_WIDTH-1:0]           out_node_id,
    output logic [3:0]                         out_degree,
    output logic [MAX_SLOTS*NODE_ID_WIDTH-1:0] out_neighbor_ids,
    output logic [MAX_SLOTS*WEIGHT_WIDTH-1:0]  out_edge_weights,
    output logic                               out_overflow,
    output logic                               out_mismatch
);

    // Last slot is never filled, so the degree always fits in four bits.
    localparam logic [3:0] CAPACITY = 4'(MAX_SLOTS - 1);

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic                       first_q, first_d;
    logic [NODE_ID_WIDTH-1:0]   id_q, id_d;
    logic [3:0]                 degree_q, degree_d;
    logic [NODE_ID_WIDTH-1:0]   nbr_q [MAX_SLOTS];
    logic [NODE_ID_WIDTH-1:0]   nbr_d [MAX_SLOTS];
    logic [WEIGHT_WIDTH-1:0]    wt_q  [MAX_SLOTS];
    logic [WEIGHT_WIDTH-1:0]    wt_d  [MAX_SLOTS];
    logic                       ovf_q, ovf_d;
    logic                       mis_q, mis_d;

    logic                       accept;
    logic                       is_edge;
    logic                       id_bad;
    logic                       self_loop;
    logic                       hit;
    logic [3:0]                 hit_idx;
    logic [WEIGHT_WIDTH:0]      sum;

    assign in_ready = (state_q == FILL) && !rst;
    assign accept   = in_valid && in_ready;

    // Next-state, slot update, duplicate search and flag tracking.
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        id_d     = id_q;
        degree_d = degree_q;
        nbr_d    = nbr_q;
        wt_d     = wt_q;
        ovf_d    = ovf_q;
        mis_d    = mis_q;
        hit      = 1'b0;
        hit_idx  = 4'd0;
        sum      = '0;

        // Only occupied slots take part in the duplicate search.
        for (int i = 0; i < MAX_SLOTS - 1; i++) begin
            if (!hit && (4'(i) < degree_q) && (nbr_q[i] == in_neighbor_id)) begin
                hit     = 1'b1;
                hit_idx = 4'(i);
            end
        end

        is_edge = accept && !in_null;
        id_bad  = is_edge && !first_q && (in_node_id != id_q);
`ifdef GRAPH_LOADER_SELF_LOOP_FILTER_EN
        // On the first beat the record id is the beat's own node id.
        self_loop = is_edge && !id_bad &&
                    (in_neighbor_id == (first_q ? in_node_id : id_q));
`else
        self_loop = 1'b0;
`endif

        case (state_q)
            FILL: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (first_q) begin
                        id_d = in_node_id;
                    end
                    if (id_bad) begin
                        mis_d = 1'b1;
                    end else if (is_edge && !self_loop) begin
                        if (hit) begin
                            sum = {1'b0, wt_q[hit_idx]} + {1'b0, in_weight};
                            wt_d[hit_idx] = sum[WEIGHT_WIDTH] ? '1 : sum[WEIGHT_WIDTH-1:0];
                        end else if (degree_q < CAPACITY) begin
                            nbr_d[degree_q] = in_neighbor_id;
                            wt_d[degree_q]  = in_weight;
                            degree_d        = degree_q + 4'd1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d  = FILL;
                    first_d  = 1'b1;
                    id_d     = '0;
                    degree_d = '0;
                    ovf_d    = 1'b0;
                    mis_d    = 1'b0;
                    for (int i = 0; i < MAX_SLOTS; i++) begin
                        nbr_d[i] = '0;
                        wt_d[i]  = '0;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Register update; reset discards any partial or held record.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            first_q  <= 1'b1;
            id_q     <= '0;
            degree_q <= '0;
            ovf_q    <= 1'b0;
            mis_q    <= 1'b0;
            for (int i = 0; i < MAX_SLOTS; i++) begin
                nbr_q[i] <= '0;
                wt_q[i]  <= '0;
            end
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            id_q     <= id_d;
            degree_q <= degree_d;
            ovf_q    <= ovf_d;
            mis_q    <= mis_d;
            nbr_q    <= nbr_d;
            wt_q     <= wt_d;
        end
    end

    assign out_valid    = (state_q == HOLD);
    assign out_node_id  = id_q;
    assign out_degree   = degree_q;
    assign out_overflow = ovf_q;
    assign out_mismatch = mis_q;

    generate
        for (genvar g = 0; g < MAX_SLOTS; g++) begin : g_pack
            assign out_neighbor_ids[g*NODE_ID_WIDTH +: NODE_ID_WIDTH] = nbr_q[g];
            assign out_edge_weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH]   = wt_q[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_primitive_graph_edge_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_primitive_graph_edge_loader
//  Description : Directed self-checking bench for primitive_graph_edge_loader.
//                Honours GRAPH_LOADER_SELF_LOOP_FILTER_EN for self-loop cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_primitive_graph_edge_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_node_id;
    logic [7:0]   in_neighbor_id;
    logic [15:0]  in_weight;
    logic         in_null;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_node_id;
    logic [3:0]   out_degree;
    logic [127:0] out_neighbor_ids;
    logic [255:0] out_edge_weights;
    logic         out_overflow;
    logic         out_mismatch;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]   exp_id [16];
    logic [15:0]  exp_w  [16];
    logic [127:0] snap_ids;
    logic [255:0] snap_w;

    primitive_graph_edge_loader #(
        .NODE_ID_WIDTH (8),
        .WEIGHT_WIDTH  (16),
        .MAX_SLOTS     (16)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_node_id       (in_node_id),
        .in_neighbor_id   (in_neighbor_id),
        .in_weight        (in_weight),
        .in_null          (in_null),
        .in_last          (in_last),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_node_id      (out_node_id),
        .out_degree       (out_degree),
        .out_neighbor_ids (out_neighbor_ids),
        .out_edge_weights (out_edge_weights),
        .out_overflow     (out_overflow),
        .out_mismatch     (out_mismatch)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) begin
            exp_id[i] = 8'd0;
            exp_w[i]  = 16'd0;
        end
    endtask

    task automatic idle_inputs();
        in_valid       = 1'b0;
        in_node_id     = 8'd0;
        in_neighbor_id = 8'd0;
        in_weight      = 16'd0;
        in_null        = 1'b0;
        in_last        = 1'b0;
    endtask

    // One beat: wait (bounded) for in_ready, present for one edge, sample at +1.
    task automatic beat(input logic [7:0] nid, input logic [7:0] nb, input logic [15:0] w,
                        input logic nul, input logic last);
        int t = 0;
        while (!in_ready && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (!in_ready) check_val("in_ready_timeout", {255'd0, in_ready}, 256'd1);
        in_valid       = 1'b1;
        in_node_id     = nid;
        in_neighbor_id = nb;
        in_weight      = w;
        in_null        = nul;
        in_last        = last;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic check_record(input string tag, input logic [7:0] nid, input logic [3:0] deg,
                                input logic ovf, input logic mis);
        logic [127:0] ei;
        logic [255:0] ew;
        for (int i = 0; i < 16; i++) begin
            ei[i*8 +: 8]   = exp_id[i];
            ew[i*16 +: 16] = exp_w[i];
        end
        check_val({tag, "_valid"},    {255'd0, out_valid},    256'd1);
        check_val({tag, "_in_ready"}, {255'd0, in_ready},     256'd0);
        check_val({tag, "_node"},     {248'd0, out_node_id},  {248'd0, nid});
        check_val({tag, "_degree"},   {252'd0, out_degree},   {252'd0, deg});
        check_val({tag, "_ids"},      {128'd0, out_neighbor_ids}, {128'd0, ei});
        check_val({tag, "_weights"},  out_edge_weights,       ew);
        check_val({tag, "_overflow"}, {255'd0, out_overflow}, {255'd0, ovf});
        check_val({tag, "_mismatch"}, {255'd0, out_mismatch}, {255'd0, mis});
    endtask

    // Accept the held record and confirm the loader returns to an empty FILL.
    task automatic release_record(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_rel_valid"},  {255'd0, out_valid},       256'd0);
        check_val({tag, "_rel_ready"},  {255'd0, in_ready},        256'd1);
        check_val({tag, "_rel_degree"}, {252'd0, out_degree},      256'd0);
        check_val({tag, "_rel_ids"},    {128'd0, out_neighbor_ids}, 256'd0);
        check_val({tag, "_rel_flags"},  {254'd0, out_overflow, out_mismatch}, 256'd0);
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        rst       = 1'b1;
        clear_exp();

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        check_val("rst_in_ready", {255'd0, in_ready},  256'd0);
        check_val("rst_valid",    {255'd0, out_valid}, 256'd0);
        check_val("rst_degree",   {252'd0, out_degree}, 256'd0);
        check_val("rst_node",     {248'd0, out_node_id}, 256'd0);
        check_val("rst_weights",  out_edge_weights, 256'd0);
        rst = 1'b0;
        #1;
        check_val("post_rst_in_ready", {255'd0, in_ready}, 256'd1);

        // Three distinct edges, latency of one cycle after the last beat
        beat(8'd5, 8'd1, 16'd10, 1'b0, 1'b0);
        beat(8'd5, 8'd2, 16'd20, 1'b0, 1'b0);
        check_val("t1_not_valid_yet", {255'd0, out_valid}, 256'd0);
        beat(8'd5, 8'd3, 16'd30, 1'b0, 1'b1);
        clear_exp();
        exp_id[0] = 8'd1; exp_w[0] = 16'd10;
        exp_id[1] = 8'd2; exp_w[1] = 16'd20;
        exp_id[2] = 8'd3; exp_w[2] = 16'd30;
        check_record("t1", 8'd5, 4'd3, 1'b0, 1'b0);
        release_record("t1");

        // Duplicate neighbour with saturating merge
        beat(8'd7, 8'd4, 16'hFFF0, 1'b0, 1'b0);
        beat(8'd7, 8'd4, 16'h0020, 1'b0, 1'b1);
        clear_exp();
        exp_id[0] = 8'd4; exp_w[0] = 16'hFFFF;
        check_record("t2", 8'd7, 4'd1, 1'b0, 1'b0);
        release_record("t2");

        // Seventeen distinct edges: first fifteen kept, overflow flagged
        for (int k = 0; k < 17; k++) begin
            beat(8'd9, 8'(20 + k), 16'(k + 1), 1'b0, (k == 16));
        end
        clear_exp();
        for (int k = 0; k < 15; k++) begin
            exp_id[k] = 8'(20 + k);
            exp_w[k]  = 16'(k + 1);
        end
        check_record("t3", 8'd9, 4'd15, 1'b1, 1'b0);
        release_record("t3");

        // Node-id mismatch, then back-pressure hold with a stray beat offered
        beat(8'd2, 8'd8,  16'd3, 1'b0, 1'b0);
        beat(8'd3, 8'd9,  16'd4, 1'b0, 1'b0);
        beat(8'd2, 8'd10, 16'd5, 1'b0, 1'b1);
        clear_exp();
        exp_id[0] = 8'd8;  exp_w[0] = 16'd3;
        exp_id[1] = 8'd10; exp_w[1] = 16'd5;
        check_record("t4", 8'd2, 4'd2, 1'b0, 1'b1);
        snap_ids = out_neighbor_ids;
        snap_w   = out_edge_weights;
        in_valid = 1'b1; in_node_id = 8'd2; in_neighbor_id = 8'd99; in_weight = 16'd7;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check_val("t4_hold_valid", {255'd0, out_valid}, 256'd1);
            check_val("t4_hold_ready", {255'd0, in_ready},  256'd0);
            check_val("t4_hold_ids",   {128'd0, out_neighbor_ids}, {128'd0, snap_ids});
            check_val("t4_hold_w",     out_edge_weights, snap_w);
        end
        idle_inputs();
        check_record("t4_after_hold", 8'd2, 4'd2, 1'b0, 1'b1);
        release_record("t4");
        check_val("t4_rel_node", {248'd0, out_node_id}, 256'd0);

        // Null terminator-only record gives a degree-0 node
        beat(8'd11, 8'd0, 16'd0, 1'b1, 1'b1);
        clear_exp();
        check_record("t5", 8'd11, 4'd0, 1'b0, 1'b0);
        release_record("t5");

        // Leading null beat latches the id; flags start clean
        beat(8'd12, 8'd0, 16'd0, 1'b1, 1'b0);
        beat(8'd12, 8'd5, 16'd1, 1'b0, 1'b1);
        clear_exp();
        exp_id[0] = 8'd5; exp_w[0] = 16'd1;
        check_record("t5b", 8'd12, 4'd1, 1'b0, 1'b0);
        release_record("t5b");

        // Self-loop handling depends on the build option
        beat(8'd6, 8'd6, 16'd5, 1'b0, 1'b0);
        beat(8'd6, 8'd1, 16'd1, 1'b0, 1'b1);
        clear_exp();
`ifdef GRAPH_LOADER_SELF_LOOP_FILTER_EN
        exp_id[0] = 8'd1; exp_w[0] = 16'd1;
        check_record("t6", 8'd6, 4'd1, 1'b0, 1'b0);
`else
        exp_id[0] = 8'd6; exp_w[0] = 16'd5;
        exp_id[1] = 8'd1; exp_w[1] = 16'd1;
        check_record("t6", 8'd6, 4'd2, 1'b0, 1'b0);
`endif
        release_record("t6");

        // Reset mid-record discards it
        beat(8'd13, 8'd2, 16'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check_val("t7_valid",    {255'd0, out_valid},  256'd0);
        check_val("t7_in_ready", {255'd0, in_ready},   256'd1);
        check_val("t7_degree",   {252'd0, out_degree}, 256'd0);
        @(posedge clk);
        #1;
        check_val("t7_no_record", {255'd0, out_valid}, 256'd0);
        beat(8'd14, 8'd3, 16'd7, 1'b0, 1'b1);
        clear_exp();
        exp_id[0] = 8'd3; exp_w[0] = 16'd7;
        check_record("t7", 8'd14, 4'd1, 1'b0, 1'b0);
        release_record("t7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/primitive_graph_edge_loader.md
Name: primitive_graph_edge_loader

Overview:
- Upstream stage of primitive_graph_node in the Empyrean Forge graph fabric.
- Consumes a serial edge stream, one edge per cycle, with valid/ready.
- Assembles one node's adjacency list, merging duplicate neighbours, and presents it as a parallel record (node id, degree, neighbour and weight slots) to the node cell via valid/ready.
- Per-record error flags report overflow and node-id mismatch.

Parameters:
NODE_ID_WIDTH, 8, width of node and neighbour ids
WEIGHT_WIDTH, 16, width of edge weights
MAX_SLOTS, 16, slots in output arrays; usable capacity is MAX_SLOTS-1 (15), so degree fits 4 bits

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  edge beat valid
in_ready  out  1  loader can accept a beat
in_node_id  in  NODE_ID_WIDTH  source node of edge
in_neighbor_id  in  NODE_ID_WIDTH  destination node
in_weight  in  WEIGHT_WIDTH  edge weight
in_null  in  1  beat carries no edge (terminator only; allows degree-0 nodes)
in_last  in  1  final beat of this node's list
out_valid  out  1  record valid
out_ready  in  1  downstream accepts record
out_node_id  out  NODE_ID_WIDTH  node id of record
out_degree  out  4  distinct neighbours stored (0..15)
out_neighbor_ids  out  MAX_SLOTS*NODE_ID_WIDTH  slot i at bits [i*NODE_ID_WIDTH +: NODE_ID_WIDTH]
out_edge_weights  out  MAX_SLOTS*WEIGHT_WIDTH  slot i likewise
out_overflow  out  1  one or more edges dropped for capacity
out_mismatch  out  1  one or more edges dropped for node-id mismatch

Behaviour:
- Reset (rst high at posedge): state FILL; all slots, out_degree, out_node_id, flags = 0; out_valid = 0. in_ready = 0 while rst is high.
- States:
  - FILL: in_ready = 1, out_valid = 0.
  - HOLD: in_ready = 0, out_valid = 1.
- FILL, beat accepted (in_valid & in_ready):
  - First beat of a record latches in_node_id as the record id, including a null beat.
  - in_null=1: no edge processing.
  - in_node_id != record id on a later beat: edge dropped, mismatch flag set.
  - in_neighbor_id equals a stored slot's id: that slot's weight += in_weight, saturating at 2^WEIGHT_WIDTH-1; degree unchanged.
  - Otherwise, if degree < 15: written to slot[degree], degree increments.
  - Otherwise (degree == 15): edge dropped, overflow flag set.
  - in_last=1: state -> HOLD next cycle. The same beat's edge is processed first.
- Duplicate compare is against the registered slots plus the current beat only, so single-cycle throughput is preserved.
- HOLD: outputs stable while out_valid & !out_ready.
  - On out_ready: next cycle state FILL, slots/degree/flags cleared, in_ready = 1.
  - Latency: last beat accepted at cycle N -> out_valid at N+1. Minimum one bubble cycle per record.
- Unused slots (index >= degree) and slot 15 always read 0.
- A null beat with in_last=0 is accepted and ignored, except that it latches the id if it is the first beat.
- Reset mid-record or mid-HOLD discards the record. No partial record is emitted.
- Weight arithmetic is unsigned. Saturation is per slot.

Optional Feature:
- Macro GRAPH_LOADER_SELF_LOOP_FILTER_EN.
- Defined: an edge with in_neighbor_id == record id is accepted and dropped, with no flag, and never occupies a slot.
- Undefined: self-loops are stored like any other edge.

Test Plan:
- Reset, then 3 edges node 5 -> (1,w10),(2,w20),(3,w30,last): out_valid 1 cycle after last, degree 3, slots 0..2 = ids 1,2,3 / weights 10,20,30, slots 3..15 zero, flags 0.
- Node 7 edges (4,w0xFFF0),(4,w0x0020,last): degree 1, slot0 weight 0xFFFF (saturated).
- 17 distinct edges for node 9: degree 15, out_overflow=1, slots 0..14 = first 15 neighbours.
- Record node 2 where beat 2 carries node_id 3: beat 2 dropped, out_mismatch=1. Hold out_ready=0 for 5 cycles: outputs stable, in_ready=0. Pulse out_ready: in_ready=1 next cycle, outputs cleared.
- Single beat in_null=1, in_last=1, node 11: record id 11, degree 0. Next record starts with clean flags.
- Self-loop edge (6->6,w5) then (6->1,w1,last): with filter macro defined, degree 1 (slot0 = id 1). Without it, degree 2. Also assert rst mid-record: no record emitted, in_ready=1 the cycle after rst deasserts.
